// File: rtl/upsample_2x_pkg.sv
// Shared types and defaults for the 2x nearest-neighbour upsampler.
package upsample_2x_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned ROW_LEN_DEF = 6;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_REPLAY = 1'b1
  } state_e;

  // Phase value that marks the first copy slot of a column.
  localparam logic BOUNDARY_PHASE = 1'b0;

  function automatic logic at_row_boundary(state_e st, logic col_zero, logic phase);
    return (st == ST_FILL) && col_zero && (phase == BOUNDARY_PHASE);
  endfunction

endpackage

// File: rtl/upsample_2x_if.sv
// Pixel stream interface: upstream pixels in, duplicated pixels out.
interface upsample_2x_if #(
  parameter int unsigned DATA_W = upsample_2x_pkg::DATA_W_DEF
);
  logic [DATA_W-1:0] in;
  logic              en;
  logic              en_up;
  logic              in_ready;
  logic [DATA_W-1:0] out;
  logic              out_en;

  modport master (output in, en, en_up, input in_ready, out, out_en);
  modport slave  (input in, en, en_up, output in_ready, out, out_en);
endinterface

// File: rtl/upsample_2x_row_buf.sv
// One-row pixel store: single write port, combinational read, no reset.
module upsample_2x_row_buf #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ROW_LEN = 6,
  parameter int unsigned CNT_W   = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [CNT_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [ROW_LEN];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/upsample_2x.sv
// 2x nearest-neighbour upsampler: each pixel twice horizontally, each row
// twice vertically; bypass passes the stream through with one cycle latency.
module upsample_2x
  import upsample_2x_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ROW_LEN = ROW_LEN_DEF
) (
  input logic          clk,
  input logic          reset,
  upsample_2x_if.slave up_if
);

  localparam int unsigned CNT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(ROW_LEN - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  col_q;
  logic              phase_q;
  logic              mode_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] out_q;
  logic              out_en_q;

  logic              boundary_c;
  logic              mode_c;
  logic              last_col_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] rd_data_c;

  // At a row boundary the incoming en_up governs this very cycle.
  assign boundary_c = at_row_boundary(state_q, col_q == '0, phase_q);
  assign mode_c     = boundary_c ? up_if.en_up : mode_q;
  assign last_col_c = (col_q == LAST_COL);
  assign wr_en_c    = (state_q == ST_FILL) && mode_c && !phase_q && up_if.en;

  assign up_if.in_ready = (state_q == ST_FILL) && (!mode_c || !phase_q);
  assign up_if.out      = out_q;
  assign up_if.out_en   = out_en_q;

  upsample_2x_row_buf #(
    .DATA_W  (DATA_W),
    .ROW_LEN (ROW_LEN),
    .CNT_W   (CNT_W)
  ) u_row_buf (
    .clk     (clk),
    .we_i    (wr_en_c),
    .waddr_i (col_q),
    .wdata_i (up_if.in),
    .raddr_i (col_q),
    .rdata_o (rd_data_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FILL;
      col_q    <= '0;
      phase_q  <= 1'b0;
      mode_q   <= 1'b0;
      hold_q   <= '0;
      out_q    <= '0;
      out_en_q <= 1'b0;
    end else begin
      if (boundary_c) mode_q <= up_if.en_up;
      case (state_q)
        ST_FILL: begin
          if (!mode_c) begin
            out_en_q <= up_if.en;
            if (up_if.en) out_q <= up_if.in;
          end else if (!phase_q) begin
            out_en_q <= up_if.en;
            if (up_if.en) begin
              hold_q  <= up_if.in;
              out_q   <= up_if.in;
              phase_q <= 1'b1;
            end
          end else begin
            // Second horizontal copy; no input accepted this cycle.
            out_q    <= hold_q;
            out_en_q <= 1'b1;
            phase_q  <= 1'b0;
            if (last_col_c) begin
              col_q   <= '0;
              state_q <= ST_REPLAY;
            end else begin
              col_q <= col_q + CNT_W'(1);
            end
          end
        end
        ST_REPLAY: begin
          out_q    <= rd_data_c;
          out_en_q <= 1'b1;
          phase_q  <= !phase_q;
          if (phase_q) begin
            if (last_col_c) begin
              col_q   <= '0;
              state_q <= ST_FILL;
            end else begin
              col_q <= col_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_2x.sv
// Directed bench for upsample_2x: queue-based stream model plus literal timing checks.
module tb_upsample_2x;

  localparam int unsigned DW    = 8;
  localparam int unsigned RL    = 6;
  localparam int          LOG_N = 2048;

  logic clk = 1'b0;
  logic reset;

  upsample_2x_if #(.DATA_W(DW)) up_if ();

  upsample_2x #(.DATA_W(DW), .ROW_LEN(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .up_if (up_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Cycle log, sampled mid-low-phase.
  int         cyc = 0;
  logic [7:0] log_out [LOG_N];
  logic       log_oen [LOG_N];
  logic       log_rdy [LOG_N];
  logic       log_en  [LOG_N];

  always @(posedge clk) cyc++;

  // Model: expected output values in order of appearance.
  logic [7:0] exp_q[$];
  logic [7:0] row_m[$];
  logic       up_m = 1'b0;

  task automatic model_accept(input logic [7:0] p);
    if (row_m.size() == 0) up_m = up_if.en_up;
    if (!up_m) begin
      exp_q.push_back(p);
    end else begin
      exp_q.push_back(p);
      exp_q.push_back(p);
      row_m.push_back(p);
      if (row_m.size() == RL) begin
        foreach (row_m[i]) begin
          exp_q.push_back(row_m[i]);
          exp_q.push_back(row_m[i]);
        end
        row_m.delete();
      end
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (cyc < LOG_N) begin
      log_out[cyc] = up_if.out;
      log_oen[cyc] = up_if.out_en;
      log_rdy[cyc] = up_if.in_ready;
      log_en[cyc]  = up_if.en;
    end
    if (!reset && up_if.out_en) begin
      if (exp_q.size() == 0) chk("extra_output", 32'(up_if.out), 32'hFFFF_FFFF);
      else chk("stream", 32'(up_if.out), 32'(exp_q.pop_front()));
    end
  end

  typedef struct {
    int         kind;  // 0 pixel, 1 gap of one ready cycle, 2 set en_up
    logic [7:0] val;
  } stim_t;

  stim_t sq[$];
  int    t_start;

  task automatic add_pix(input logic [7:0] v);
    sq.push_back('{kind: 0, val: v});
  endtask
  task automatic add_gap();
    sq.push_back('{kind: 1, val: 8'h00});
  endtask
  task automatic add_mode(input logic v);
    sq.push_back('{kind: 2, val: {7'b0, v}});
  endtask

  task automatic run();
    logic r;
    logic acc;
    bit   first = 1'b1;
    foreach (sq[k]) begin
      case (sq[k].kind)
        0: begin
          @(negedge clk);
          up_if.in = sq[k].val;
          up_if.en = 1'b1;
          if (first) begin t_start = cyc; first = 1'b0; end
          acc = 1'b0;
          for (int n = 0; n < 200; n++) begin
            #1 r = up_if.in_ready;
            @(posedge clk);
            if (r) begin acc = 1'b1; break; end
            @(negedge clk);
          end
          if (acc) model_accept(sq[k].val);
          else chk("accept_timeout", 32'd0, 32'd1);
        end
        1: begin
          acc = 1'b0;
          for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            up_if.en = 1'b0;
            #1 r = up_if.in_ready;
            @(posedge clk);
            if (r) begin acc = 1'b1; break; end
          end
          if (!acc) chk("gap_timeout", 32'd0, 32'd1);
        end
        default: up_if.en_up = sq[k].val[0];
      endcase
    end
    @(negedge clk);
    up_if.en = 1'b0;
    sq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    up_if.en = 1'b0;
  endtask

  logic [7:0] basic_exp [24] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03,
                                 8'h04, 8'h04, 8'h05, 8'h05, 8'h06, 8'h06,
                                 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03,
                                 8'h04, 8'h04, 8'h05, 8'h05, 8'h06, 8'h06};

  initial begin
    int t;
    int bad;
    up_if.in    = '0;
    up_if.en    = 1'b0;
    up_if.en_up = 1'b1;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_out", 32'(up_if.out), 32'd0);
    chk("reset_out_en", 32'(up_if.out_en), 32'd0);
    chk("reset_in_ready", 32'(up_if.in_ready), 32'd1);

    // Basic row
    for (int i = 1; i <= 6; i++) add_pix(8'(i));
    run();
    t = t_start;
    idle(30);
    bad = 0;
    for (int i = 0; i < 24; i++)
      if (log_rdy[t+i] !== ((i < 12) && (i % 2 == 0))) bad++;
    chk("basic_in_ready_pattern", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 1; i <= 24; i++) if (log_oen[t+i] !== 1'b1) bad++;
    chk("basic_out_en_run", 32'(bad), 32'd0);
    chk("basic_out_en_after", 32'(log_oen[t+25]), 32'd0);
    bad = 0;
    for (int i = 0; i < 24; i++) if (log_out[t+1+i] !== basic_exp[i]) bad++;
    chk("basic_values", 32'(bad), 32'd0);

    // Back-to-back rows
    for (int i = 1; i <= 6; i++) add_pix(8'(i));
    for (int i = 0; i < 6; i++) add_pix(8'h11 + 8'(i));
    run();
    t = t_start;
    idle(30);
    chk("b2b_row2_accept_cycle", 32'(log_rdy[t+24] && log_en[t+24]), 32'd1);
    chk("b2b_row2_first_out", 32'(log_out[t+25]), 32'h11);
    bad = 0;
    for (int i = 1; i <= 60; i++) if (log_oen[t+i] === 1'b1) bad++;
    chk("b2b_valid_count", 32'(bad), 32'd48);

    // en gaps
    add_pix(8'h0A); add_pix(8'h0B); add_pix(8'h0C);
    add_gap(); add_gap(); add_gap();
    add_pix(8'h0D); add_pix(8'h0E); add_pix(8'h0F);
    run();
    t = t_start;
    idle(30);
    bad = 0;
    for (int i = 1; i <= 27; i++) if (log_oen[t+i] !== 1'b1) bad++;
    chk("gap_out_en_drops", 32'(bad), 32'd3);
    chk("gap_out_held", 32'(log_out[t+7]), 32'h0C);
    bad = 0;
    for (int i = 16; i <= 27; i++) if (log_oen[t+i] === 1'b1) bad++;
    chk("gap_replay_contiguous", 32'(bad), 32'd12);
    chk("gap_out_en_after", 32'(log_oen[t+28]), 32'd0);

    // Bypass
    up_if.en_up = 1'b0;
    idle(2);
    for (int i = 0; i < 28; i++) begin
      add_pix(8'h20 + 8'(i));
      if (i == 5 || i == 16) add_gap();
    end
    run();
    t = t_start;
    idle(5);
    bad = 0;
    for (int i = 0; i < 30; i++) if (log_rdy[t+i] !== 1'b1) bad++;
    chk("bypass_in_ready", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) if (log_oen[t+i+1] !== log_en[t+i]) bad++;
    chk("bypass_out_en_delay", 32'(bad), 32'd0);
    chk("bypass_first", 32'(log_out[t+1]), 32'h20);
    chk("bypass_gap_hold", 32'({log_oen[t+7], log_out[t+7]}), 32'h025);

    // Mode switch mid-row
    up_if.en_up = 1'b1;
    idle(2);
    add_pix(8'h41); add_pix(8'h42); add_pix(8'h43);
    add_mode(1'b0);
    add_pix(8'h44); add_pix(8'h45); add_pix(8'h46);
    add_pix(8'h51); add_pix(8'h52); add_pix(8'h53);
    run();
    t = t_start;
    idle(10);
    chk("switch_replay_first", 32'(log_out[t+13]), 32'h41);
    chk("switch_bypass_first", 32'({log_oen[t+25], log_out[t+25]}), 32'h151);
    chk("switch_bypass_ready", 32'({log_rdy[t+24], log_rdy[t+25], log_rdy[t+26]}), 32'h7);
    bad = 0;
    for (int i = 1; i <= 28; i++) if (log_oen[t+i] === 1'b1) bad++;
    chk("switch_valid_count", 32'(bad), 32'd27);

    // Reset during replay
    up_if.en_up = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) add_pix(8'h61 + 8'(i));
    run();
    t = t_start;
    while (cyc < t + 17) @(negedge clk);
    #4 reset = 1'b1;
    #1;
    chk("rst_mid_before", 32'(log_out[t+17]), 32'h63);
    chk("rst_mid_out", 32'(up_if.out), 32'd0);
    chk("rst_mid_out_en", 32'(up_if.out_en), 32'd0);
    exp_q.delete();
    row_m.delete();
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    for (int i = 0; i < 6; i++) add_pix(8'h31 + 8'(i));
    run();
    t = t_start;
    idle(30);
    chk("rst_new_first", 32'(log_out[t+1]), 32'h31);
    chk("rst_new_replay_first", 32'(log_out[t+13]), 32'h31);
    bad = 0;
    for (int i = 1; i <= 25; i++) if (log_oen[t+i] === 1'b1) bad++;
    chk("rst_new_valid_count", 32'(bad), 32'd24);

    chk("model_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/upsample_2x.md
Name: upsample_2x

Overview:
- 2x nearest-neighbour upsampler (unpooling) for the feature-map stream; the inverse direction of the maxpooling stage.
- Consumes one 8-bit pixel per accepted cycle, row-major, ROW_LEN pixels per row.
- Emits each pixel twice horizontally and each row twice vertically, on the same en/out_en stream convention used by the pooling path.
- Sits between decoder-side layers and the next conv/stream consumer.

Parameters:
- DATA_W, 8, pixel width.
- ROW_LEN, 6, input pixels per row. Output row is 2*ROW_LEN.
- CNT_W, $clog2(ROW_LEN), column counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  DATA_W  input pixel.
- en  input  1  input valid; pixel consumed only when en && in_ready.
- en_up  input  1  1 = upsample mode, 0 = bypass; sampled at row boundaries only.
- in_ready  output  1  block can accept a pixel this cycle.
- out  output  DATA_W  output pixel (registered).
- out_en  output  1  out valid this cycle (registered).

Behaviour:
- Reset state (asynchronous assert on reset=1):
  - out=0, out_en=0, state=FILL, col=0, phase=0.
  - mode register is loaded from en_up on the first row boundary after reset.
  - Row buffer contents are not cleared; they are don't-care.
- Row boundary = FILL with col=0 and phase=0. At every row boundary, mode <= en_up. Changes to en_up anywhere else have no effect until the next boundary.
- Bypass (mode=0):
  - in_ready=1 at all times.
  - Each cycle: out <= in when en=1, otherwise out holds; out_en <= en.
  - Latency is 1 cycle.
- Upsample (mode=1), states FILL and REPLAY.
- FILL, phase=0:
  - in_ready=1.
  - On en=1: buf[col] <= in, hold <= in, out <= in, out_en <= 1, phase <= 1.
  - On en=0: out_en <= 0, out holds, nothing else changes.
- FILL, phase=1:
  - in_ready=0.
  - out <= hold, out_en <= 1, phase <= 0.
  - If col==ROW_LEN-1: col <= 0, state <= REPLAY. Otherwise col <= col+1.
- REPLAY:
  - in_ready=0. out_en=1 on every cycle, unconditionally, with no dependence on en.
  - out <= buf[col]; phase toggles each cycle; col increments when phase=1.
  - After 2*ROW_LEN cycles (col==ROW_LEN-1 and phase=1): col <= 0, phase <= 0, state <= FILL.
- Latency and throughput:
  - First copy of a pixel appears 1 cycle after acceptance; second copy follows in the next cycle.
  - Replayed row starts the cycle right after the last pixel's second copy, so the output row pair is gap-free if input is gap-free.
  - Peak input rate is ROW_LEN pixels per 4*ROW_LEN cycles.
- en=1 while in_ready=0: ignored; upstream holds the pixel until in_ready=1.
- Gaps in en during FILL stretch the first output row (out_en=0 cycles). The replayed row is always contiguous.
- Reset mid-FILL or mid-REPLAY: partial row is discarded; the next accepted pixel is column 0.
- No overflow is possible: buffer depth = ROW_LEN, and writes occur only in FILL.

Decomposition:
- Shared package npu_pkg: DATA_W default, ST_FILL/ST_REPLAY state encoding, row-boundary helper constant.
- Sub-module upsample_row_buf: ROW_LEN x DATA_W register array.
  - One write port, one combinational read port, no reset.
- Top module holds FSM, col/phase counters, hold register, mode register, output registers.

Test Plan:
- Basic row (mode=1, ROW_LEN=6): feed 01..06 with en held high from cycle 0.
  - in_ready alternates 1,0 for 12 cycles, then 0 for 12.
  - out_en=1 for 24 consecutive cycles from cycle 1.
  - out = 01,01,02,02,…,06,06,01,01,…,06,06.
- Back-to-back rows: rows 01..06 then 11..16 with en always high.
  - Second row's first pixel 11 is accepted on cycle 24 and appears at cycle 25.
  - 48 total valid outputs; no pixel is lost or duplicated beyond 4x.
- en gaps: row 0A..0F with en low for 3 cycles after pixel 0C.
  - out_en drops for exactly 3 cycles; output values are unchanged.
  - REPLAY is 12 contiguous valid cycles.
- Bypass: en_up=0, in = 20..3B with en=1.
  - out follows in with 1-cycle latency; out_en = en delayed by 1; in_ready stays 1.
- Mode switch: toggle en_up 1->0 mid-row (after pixel 03).
  - Upsampling continues through REPLAY.
  - Bypass starts at the next row boundary.
- Reset during REPLAY (after 5 replay outputs):
  - out=0 and out_en=0 immediately, asynchronously.
  - After release, new row 31..36 produces correct 31,31,… with no stale data.
